// File: rtl/dcache_assoc_if.sv
// Datapath-side and bus-side handshake bundles for the associative data cache.

interface datapath_cache_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic        halt;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;

    modport dcache (input dmemREN, dmemWEN, halt, dmemaddr, dmemstore,
                    output dhit, dmemload, flushed);
    modport dp     (output dmemREN, dmemWEN, halt, dmemaddr, dmemstore,
                    input dhit, dmemload, flushed);
endinterface

interface cache_control_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport dcache (output dREN, dWEN, daddr, dstore,
                    input dload, dwait);
    modport cc     (input dREN, dWEN, daddr, dstore,
                    output dload, dwait);
endinterface

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache with true-LRU replacement,
// halt-time flush of dirty lines and a final hit-count write.

module dcache_assoc #(
    parameter int          CPUID   = 0,
    parameter int          NSETS   = 8,
    parameter int          NWAYS   = 2,
    parameter int          WORDS   = 2,
    parameter logic [31:0] HITADDR = 32'h3100
) (
    input logic             CLK,
    input logic             RST,
    datapath_cache_if.dcache dcif,
    cache_control_if.dcache  ccif
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(NSETS);
    localparam int TW = 30 - OW - IW;
    localparam int AW = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (NSETS < 2 || NWAYS < 1 || NWAYS > 8 || WORDS < 1 || WORDS > 8 || CPUID < 0) begin : g_bad_param
        $error("dcache_assoc: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH_SCAN, FLUSH_WB, HITCNT, DONE} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   vway_q, vway_d, fway_q, fway_d;
    logic [IW-1:0]   fset_q, fset_d;
    logic [31:0]     hits_q, hits_d;
    logic            valid_q [NSETS][NWAYS], valid_d [NSETS][NWAYS];
    logic            dirty_q [NSETS][NWAYS], dirty_d [NSETS][NWAYS];
    logic [TW-1:0]   tag_q   [NSETS][NWAYS], tag_d   [NSETS][NWAYS];
    logic [AW-1:0]   age_q   [NSETS][NWAYS], age_d   [NSETS][NWAYS];
    logic [31:0]     data_q  [NSETS][NWAYS][WORDS];
    logic            dren_q, dren_d, dwen_q, dwen_d, flushed_q, flushed_d;
    logic [31:0]     daddr_q, daddr_d, dstore_q, dstore_d;

    logic            data_we;
    logic [IW-1:0]   data_set;
    logic [AW-1:0]   data_way;
    logic [WW-1:0]   data_word;
    logic [31:0]     data_wdata;

    logic [TW-1:0]   req_tag;
    logic [IW-1:0]   req_idx;
    logic [WW-1:0]   req_off;
    logic            hit, vic_found;
    logic [AW-1:0]   hway, vic;
    logic            line_last, flush_last, req;
    logic            unused_byte;

    function automatic logic [31:0] mkaddr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                           input logic [WW-1:0] c);
        return (32'(t) << (2 + OW + IW)) | (32'(i) << (2 + OW)) |
               ((WORDS > 1) ? (32'(c) << 2) : 32'd0);
    endfunction

    assign unused_byte = ^dcif.dmemaddr[1:0];
    assign req_tag = TW'(dcif.dmemaddr >> (2 + OW + IW));
    assign req_idx = IW'(dcif.dmemaddr >> (2 + OW));
    assign req_off = (WORDS > 1) ? WW'(dcif.dmemaddr >> 2) : '0;
    assign req     = dcif.dmemREN | dcif.dmemWEN;

    always_comb begin
        hit       = 1'b0;
        hway      = '0;
        vic_found = 1'b0;
        vic       = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit  = 1'b1;
                hway = AW'(w);
            end
            if (!vic_found && !valid_q[req_idx][w]) begin
                vic_found = 1'b1;
                vic       = AW'(w);
            end
        end
        // With all ways valid, the oldest way carries the unique maximum age.
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!vic_found && age_q[req_idx][w] == AW'(NWAYS - 1))
                vic = AW'(w);
        end
    end

    assign dcif.dhit     = (state_q == IDLE) && !dcif.halt && req && hit;
    assign dcif.dmemload = data_q[req_idx][hway][req_off];
    assign dcif.flushed  = flushed_q;
    assign ccif.dREN     = dren_q;
    assign ccif.dWEN     = dwen_q;
    assign ccif.daddr    = daddr_q;
    assign ccif.dstore   = dstore_q;

    assign line_last  = (cnt_q == WW'(WORDS - 1));
    assign flush_last = (fset_q == IW'(NSETS - 1)) && (fway_q == AW'(NWAYS - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vway_d     = vway_q;
        fset_d     = fset_q;
        fway_d     = fway_q;
        hits_d     = hits_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        age_d      = age_q;
        data_we    = 1'b0;
        data_set   = req_idx;
        data_way   = vway_q;
        data_word  = cnt_q;
        data_wdata = ccif.dload;

        case (state_q)
            IDLE: begin
                if (dcif.halt) begin
                    state_d = FLUSH_SCAN;
                end else if (req && hit) begin
                    hits_d = hits_q + 32'd1;
                    for (int unsigned k = 0; k < NWAYS; k++)
                        if (age_q[req_idx][k] < age_q[req_idx][hway])
                            age_d[req_idx][k] = age_q[req_idx][k] + AW'(1);
                    age_d[req_idx][hway] = '0;
                    if (dcif.dmemWEN) begin
                        data_we    = 1'b1;
                        data_way   = hway;
                        data_word  = req_off;
                        data_wdata = dcif.dmemstore;
                        dirty_d[req_idx][hway] = 1'b1;
                    end
                end else if (req) begin
                    vway_d  = vic;
                    cnt_d   = '0;
                    state_d = (valid_q[req_idx][vic] && dirty_q[req_idx][vic]) ? WB : FETCH;
                end
            end
            WB: begin
                if (!ccif.dwait) begin
                    cnt_d = line_last ? '0 : cnt_q + WW'(1);
                    if (line_last) state_d = FETCH;
                end
            end
            FETCH: begin
                if (!ccif.dwait) begin
                    data_we = 1'b1;
                    cnt_d   = line_last ? '0 : cnt_q + WW'(1);
                    if (line_last) begin
                        valid_d[req_idx][vway_q] = 1'b1;
                        dirty_d[req_idx][vway_q] = 1'b0;
                        tag_d[req_idx][vway_q]   = req_tag;
                        hits_d  = hits_q - 32'd1;
                        state_d = IDLE;
                    end
                end
            end
            FLUSH_SCAN, FLUSH_WB: begin
                if (state_q == FLUSH_SCAN && valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
                    cnt_d   = '0;
                    state_d = FLUSH_WB;
                end else if (state_q == FLUSH_WB && (ccif.dwait || !line_last)) begin
                    if (!ccif.dwait) cnt_d = cnt_q + WW'(1);
                end else begin
                    // Line done (clean, or last word written back): drop it and move on.
                    valid_d[fset_q][fway_q] = 1'b0;
                    dirty_d[fset_q][fway_q] = 1'b0;
                    cnt_d = '0;
                    if (flush_last) begin
                        state_d = HITCNT;
                    end else begin
                        state_d = FLUSH_SCAN;
                        if (fway_q == AW'(NWAYS - 1)) begin
                            fway_d = '0;
                            fset_d = fset_q + IW'(1);
                        end else begin
                            fway_d = fway_q + AW'(1);
                        end
                    end
                end
            end
            HITCNT: if (!ccif.dwait) state_d = DONE;
            default: state_d = DONE;
        endcase

        dren_d   = 1'b0;
        dwen_d   = 1'b0;
        daddr_d  = '0;
        dstore_d = '0;
        case (state_d)
            WB: begin
                dwen_d   = 1'b1;
                daddr_d  = mkaddr(tag_q[req_idx][vway_d], req_idx, cnt_d);
                dstore_d = data_q[req_idx][vway_d][cnt_d];
            end
            FETCH: begin
                dren_d  = 1'b1;
                daddr_d = mkaddr(req_tag, req_idx, cnt_d);
            end
            FLUSH_WB: begin
                dwen_d   = 1'b1;
                daddr_d  = mkaddr(tag_q[fset_d][fway_d], fset_d, cnt_d);
                dstore_d = data_q[fset_d][fway_d][cnt_d];
            end
            HITCNT: begin
                dwen_d   = 1'b1;
                daddr_d  = HITADDR;
                dstore_d = hits_d;
            end
            default: ;
        endcase
        flushed_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vway_q    <= '0;
            fset_q    <= '0;
            fway_q    <= '0;
            hits_q    <= '0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= '0;
            dstore_q  <= '0;
            flushed_q <= 1'b0;
            for (int unsigned s = 0; s < NSETS; s++)
                for (int unsigned w = 0; w < NWAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AW'(w);
                end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vway_q    <= vway_d;
            fset_q    <= fset_d;
            fway_q    <= fway_d;
            hits_q    <= hits_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            daddr_q   <= daddr_d;
            dstore_q  <= dstore_d;
            flushed_q <= flushed_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            age_q     <= age_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (data_we) data_q[data_set][data_way][data_word] <= data_wdata;
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed requests push expected hits and bus
// transactions; a negedge monitor pops and compares as the DUT presents them.

module tb_dcache_assoc;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    datapath_cache_if dcif();
    cache_control_if  ccif();

    dcache_assoc #(.CPUID(0), .NSETS(8), .NWAYS(2), .WORDS(2), .HITADDR(32'h3100)) dut (
        .CLK(CLK), .RST(RST), .dcif(dcif), .ccif(ccif));

    typedef struct { logic wen; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic chk; logic [31:0] data; } hit_t;

    bus_t        exp_bus[$];
    hit_t        exp_hit[$];
    int          total = 0;
    int          bad = 0;
    int          wen_accepts = 0;
    logic [31:0] mem [logic [31:0]];
    logic        stall_en = 1'b0;
    logic        hold_wait = 1'b0;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hC0DE0000 | {16'h0, a[15:0]});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_r(input logic [31:0] a);
        exp_bus.push_back('{wen: 1'b0, addr: a, data: 32'h0});
    endtask
    task automatic bus_w(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{wen: 1'b1, addr: a, data: d});
    endtask
    task automatic exp_read(input logic [31:0] d);
        exp_hit.push_back('{chk: 1'b1, data: d});
    endtask
    task automatic exp_write();
        exp_hit.push_back('{chk: 1'b0, data: 32'h0});
    endtask

    // Memory side: dwait and dload are decided just after each rising edge.
    initial begin
        int scnt;
        scnt = 0;
        ccif.dwait = 1'b0;
        ccif.dload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (hold_wait) begin
                ccif.dwait = 1'b1;
            end else if (stall_en && (ccif.dREN || ccif.dWEN)) begin
                if (scnt < 5) begin
                    ccif.dwait = 1'b1;
                    scnt++;
                end else begin
                    ccif.dwait = 1'b0;
                    scnt = 0;
                end
            end else begin
                ccif.dwait = 1'b0;
                scnt = 0;
            end
            ccif.dload = memrd(ccif.daddr);
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_store;
    always @(negedge CLK) begin
        bus_t b;
        hit_t h;
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (dcif.dhit) begin
                if (exp_hit.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_hit: addr %h", dcif.dmemaddr);
                end else begin
                    h = exp_hit.pop_front();
                    if (h.chk) check("dmemload", dcif.dmemload, h.data);
                end
            end
            if (ccif.dREN && ccif.dWEN) begin
                total++; bad++;
                $display("FAIL ren_and_wen: both asserted at %h", ccif.daddr);
            end
            if ((ccif.dREN || ccif.dWEN) && prev_stall) begin
                check("stall_daddr", ccif.daddr, prev_addr);
                check("stall_dstore", ccif.dstore, prev_store);
            end
            if ((ccif.dREN || ccif.dWEN) && !ccif.dwait) begin
                if (exp_bus.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bus: wen %b addr %h", ccif.dWEN, ccif.daddr);
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_wen", 32'(ccif.dWEN), 32'(b.wen));
                    check("bus_addr", ccif.daddr, b.addr);
                    if (b.wen) check("bus_dstore", ccif.dstore, b.data);
                end
                if (ccif.dWEN) begin
                    mem[ccif.daddr] = ccif.dstore;
                    wen_accepts++;
                end
            end
            prev_stall = (ccif.dREN || ccif.dWEN) && ccif.dwait;
            prev_addr  = ccif.daddr;
            prev_store = ccif.dstore;
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        dcif.dmemREN = 1'b0;
        dcif.dmemWEN = 1'b0;
        dcif.halt = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    task automatic do_req(input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input string name);
        int n;
        @(posedge CLK);
        #2;
        dcif.dmemREN = ren;
        dcif.dmemWEN = wen;
        dcif.dmemaddr = a;
        dcif.dmemstore = d;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dcif.dhit && n < 200);
        total++;
        if (!dcif.dhit) begin
            bad++;
            $display("FAIL %s_timeout: no dhit for addr %h", name, a);
        end else if (exp_lat > 0 && n != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, exp_lat);
        end
        @(posedge CLK);
        #2;
        dcif.dmemREN = 1'b0;
        dcif.dmemWEN = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(negedge CLK);
        check({name, "_bus_queue"}, exp_bus.size(), 0);
        check({name, "_hit_queue"}, exp_hit.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0;
        dcif.dmemaddr = '0;
        dcif.dmemstore = '0;
        mem[32'h80] = 32'h11111111;
        mem[32'h84] = 32'h22222222;
        do_reset();

        @(negedge CLK);
        check("rst_dhit", 32'(dcif.dhit), 0);
        check("rst_flushed", 32'(dcif.flushed), 0);
        check("rst_dREN", 32'(ccif.dREN), 0);
        check("rst_dWEN", 32'(ccif.dWEN), 0);
        check("rst_daddr", ccif.daddr, 0);
        check("rst_dstore", ccif.dstore, 0);

        // Clean read miss, then same-block hit.
        bus_r(32'h80); bus_r(32'h84); exp_read(32'h11111111);
        do_req(1, 0, 32'h80, 0, 4, "clean_miss");
        exp_read(32'h22222222);
        do_req(1, 0, 32'h84, 0, 1, "block_hit");

        // Dirty eviction of way 0.
        exp_write();
        do_req(0, 1, 32'h80, 32'hDEADBEEF, 1, "write_hit");
        bus_r(32'h180); bus_r(32'h184); exp_read(32'hC0DE0180);
        do_req(1, 0, 32'h180, 0, 4, "fill_way1");
        bus_w(32'h80, 32'hDEADBEEF); bus_w(32'h84, 32'h22222222);
        bus_r(32'h280); bus_r(32'h284); exp_read(32'hC0DE0280);
        do_req(1, 0, 32'h280, 0, 6, "dirty_miss");
        check_drained("dirty");

        // LRU: re-reading 0x80 makes the 0x180 way the victim.
        do_reset();
        bus_r(32'h80); bus_r(32'h84); exp_read(32'hDEADBEEF);
        do_req(1, 0, 32'h80, 0, 4, "lru_fill0");
        bus_r(32'h180); bus_r(32'h184); exp_read(32'hC0DE0180);
        do_req(1, 0, 32'h180, 0, 4, "lru_fill1");
        exp_read(32'hDEADBEEF);
        do_req(1, 0, 32'h80, 0, 1, "lru_touch");
        bus_r(32'h280); bus_r(32'h284); exp_read(32'hC0DE0280);
        do_req(1, 0, 32'h280, 0, 4, "lru_miss");
        exp_read(32'hDEADBEEF);
        do_req(1, 0, 32'h80, 0, 1, "lru_survivor");
        bus_r(32'h180); bus_r(32'h184); exp_read(32'hC0DE0180);
        do_req(1, 0, 32'h180, 0, 4, "lru_evicted");
        check_drained("lru");

        // Stalled write-back: 5 wait cycles per word.
        do_reset();
        stall_en = 1'b1;
        bus_r(32'h88); bus_r(32'h8C); exp_read(32'hC0DE0088);
        do_req(1, 0, 32'h88, 0, 0, "stall_fill0");
        exp_write();
        do_req(0, 1, 32'h88, 32'h5A5A0088, 1, "stall_whit");
        bus_r(32'h188); bus_r(32'h18C); exp_read(32'hC0DE0188);
        do_req(1, 0, 32'h188, 0, 0, "stall_fill1");
        w0 = wen_accepts;
        bus_w(32'h88, 32'h5A5A0088); bus_w(32'h8C, 32'hC0DE008C);
        bus_r(32'h288); bus_r(32'h28C); exp_read(32'hC0DE0288);
        do_req(1, 0, 32'h288, 0, 0, "stall_dirty");
        check("stall_wb_count", wen_accepts - w0, 2);
        stall_en = 1'b0;
        check_drained("stall");

        // Reset pulse while a fetch is stalled.
        do_reset();
        hold_wait = 1'b1;
        @(posedge CLK);
        #2;
        dcif.dmemREN = 1'b1;
        dcif.dmemaddr = 32'h100;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!ccif.dREN && n < 20);
        check("midfetch_dREN_up", 32'(ccif.dREN), 1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        dcif.dmemREN = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        hold_wait = 1'b0;
        @(negedge CLK);
        check("midfetch_dREN_down", 32'(ccif.dREN), 0);
        check("midfetch_dWEN", 32'(ccif.dWEN), 0);
        bus_r(32'h100); bus_r(32'h104); exp_read(32'hC0DE0100);
        do_req(1, 0, 32'h100, 0, 4, "rst_reread");
        check_drained("midfetch");

        // Halt flush: dirty set0/way1 and set3/way0, three first-try hits.
        do_reset();
        bus_r(32'h00); bus_r(32'h04); exp_read(32'hC0DE0000);
        do_req(1, 0, 32'h00, 0, 4, "h_fill00");
        bus_r(32'h80); bus_r(32'h84); exp_write();
        do_req(0, 1, 32'h80, 32'h44440080, 4, "h_wmiss80");
        bus_r(32'h18); bus_r(32'h1C); exp_write();
        do_req(0, 1, 32'h18, 32'h33330018, 4, "h_wmiss18");
        exp_read(32'hC0DE0000);
        do_req(1, 0, 32'h00, 0, 1, "h_hit0");
        exp_read(32'hC0DE0004);
        do_req(1, 0, 32'h04, 0, 1, "h_hit1");
        exp_read(32'h33330018);
        do_req(1, 0, 32'h18, 0, 1, "h_hit2");
        bus_w(32'h80, 32'h44440080); bus_w(32'h84, 32'h22222222);
        bus_w(32'h18, 32'h33330018); bus_w(32'h1C, 32'hC0DE001C);
        bus_w(32'h3100, 32'd3);
        @(posedge CLK);
        #2 dcif.halt = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dcif.flushed && n < 100);
        check("flushed_up", 32'(dcif.flushed), 1);
        repeat (3) @(negedge CLK);
        check("flushed_held", 32'(dcif.flushed), 1);
        check("done_dWEN", 32'(ccif.dWEN), 0);
        check("done_dREN", 32'(ccif.dREN), 0);
        check("done_dhit", 32'(dcif.dhit), 0);
        check_drained("flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
